// File: rtl/uart_transmitter_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer that drives serial_out.
// Latency: a push into an empty FIFO while idle starts the start bit on the next cycle; a frame is 10 symbol times.
// Backpressure: data_in_ready is low only while the FIFO is full or reset is asserted.
module uart_transmitter_buffered #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [7:0]                       data_in,
   input  logic                             data_in_valid,
   output logic                             data_in_ready,
   output logic                             serial_out,
   output logic                             tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int BW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic           serial_q, serial_d;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count_q;

   logic           full, empty, push, pop, bit_end;

   assign full          = (count_q == CNT_FULL);
   assign empty         = (count_q == '0);
   assign data_in_ready = !full && !rst;
   assign push          = data_in_valid && data_in_ready;
   assign bit_end       = (baud_q == BAUD_LAST);

   assign serial_out = serial_q;
   assign tx_busy    = (state_q != IDLE) || !empty;
   assign fifo_count = count_q;

   // Next-state, pop request and next line level; the head byte is popped on the edge entering START.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      baud_d    = bit_end ? '0 : baud_q + BAUD_ONE;
      pop       = 1'b0;
      serial_d  = 1'b1;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = mem[rd_ptr];
               bit_idx_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  // Chain straight into the next frame with no idle gap.
                  pop       = 1'b1;
                  shift_d   = mem[rd_ptr];
                  bit_idx_d = '0;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered so serial_out comes straight off a flop.
      case (state_d)
         IDLE:    serial_d = 1'b1;
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         default: serial_d = 1'b1;
      endcase
   end

   // Serializer state, shift register, bit index, baud counter and registered line output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         baud_q    <= '0;
         serial_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         baud_q    <= baud_d;
         serial_q  <= serial_d;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; a same-slot pop reads the old entry because the write lands at the edge.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

endmodule

// File: tb/tb_uart_transmitter_buffered.sv
`timescale 1ns/1ps
// Bench for the buffered UART transmitter: queue-based reference model, decoupled line monitor, default-rate frame check.
module tb_uart_transmitter_buffered;
   localparam int CF    = 1000;
   localparam int BR    = 100;
   localparam int SET   = CF / BR;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * SET;
   localparam int DSET  = 50_000_000 / 115_200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, data_in_valid, data_in_ready, serial_out, tx_busy;
   logic [7:0] data_in;
   logic [3:0] fifo_count;

   logic       d_rst, d_valid, d_ready, d_serial, d_busy;
   logic [7:0] d_data;
   logic [3:0] d_count;

   uart_transmitter_buffered #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
      .fifo_count(fifo_count));

   uart_transmitter_buffered dut_def (
      .clk(clk), .rst(d_rst), .data_in(d_data), .data_in_valid(d_valid),
      .data_in_ready(d_ready), .serial_out(d_serial), .tx_busy(d_busy),
      .fifo_count(d_count));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] b;
      longint     start;
   } frame_t;

   logic [7:0] mq[$];      // bytes waiting in the transmit buffer
   frame_t     exp_q[$];   // frames the line must carry, in order
   bit         m_active = 0;
   longint     m_end = 0;  // last cycle of the frame on the line
   longint     cyc = 0;
   bit         rst_edge = 0;
   bit         checking = 0;

   initial forever begin
      longint c;
      bit     pop_ok, do_push;
      @(posedge clk);
      c = cyc;
      if (rst) begin
         mq.delete();
         exp_q.delete();
         m_active = 0;
         checking = 1;
      end else begin
         pop_ok  = !m_active || (c == m_end);
         do_push = data_in_valid && (mq.size() < DEPTH);
         if (m_active && c == m_end) m_active = 0;
         if (pop_ok && mq.size() != 0) begin
            frame_t f;
            f.b     = mq.pop_front();
            f.start = c + 1;
            exp_q.push_back(f);
            m_active = 1;
            m_end    = c + FRAME;
         end
         if (do_push) mq.push_back(data_in);
      end
      rst_edge = rst;
      cyc = c + 1;
   end

   // ---------------- per-cycle status checks ----------------
   initial forever begin
      @(negedge clk);
      if (checking) begin
         check("data_in_ready", data_in_ready, (!rst && mq.size() < DEPTH));
         check("fifo_count", fifo_count, mq.size());
         check("tx_busy", tx_busy, (m_active || mq.size() != 0));
         if (rst_edge) check("line_high_in_reset", serial_out, 1);
      end
   end

   // ---------------- line monitor / scoreboard ----------------
   bit     mon_active = 0;
   bit     mon_phantom = 0;
   int     mon_pos, mon_bad;
   longint mon_start;
   frame_t cur;

   initial forever begin
      int   k;
      logic exp_bit;
      @(negedge clk);
      if (checking) begin
         if (rst_edge) begin
            mon_active = 0;
         end else begin
            if (!mon_active && serial_out !== 1'b1) begin
               mon_active = 1;
               mon_pos    = 0;
               mon_bad    = 0;
               mon_start  = cyc;
               if (exp_q.size() == 0) begin
                  check("line_idle_no_frame_due", serial_out, 1);
                  mon_phantom = 1;
               end else begin
                  cur = exp_q.pop_front();
                  mon_phantom = 0;
               end
            end
            if (mon_active) begin
               k = mon_pos / SET;
               if (k == 0)      exp_bit = 1'b0;
               else if (k == 9) exp_bit = 1'b1;
               else             exp_bit = cur.b[3'(k - 1)];
               if (!mon_phantom && serial_out !== exp_bit) mon_bad++;
               mon_pos++;
               if (mon_pos == FRAME) begin
                  mon_active = 0;
                  if (!mon_phantom) begin
                     check($sformatf("frame_start_%02h", cur.b), mon_start, cur.start);
                     check($sformatf("frame_bad_bit_cycles_%02h", cur.b), mon_bad, 0);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] b);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      data_in = b;
      data_in_valid = 1'b1;
      while (!acc && t < 5000) begin
         @(negedge clk);
         acc = data_in_ready;
         tick();
         t++;
      end
      data_in_valid = 1'b0;
      if (!acc) check("send_accept_timeout", data_in_ready, 1);
   endtask

   task automatic wait_idle(input int limit);
      int t;
      t = 0;
      while ((m_active || mq.size() != 0 || mon_active || exp_q.size() != 0) && t < limit) begin
         tick();
         t++;
      end
      if (t >= limit) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", t);
      end
      repeat (3) tick();
   endtask

   // ---------------- default-rate frame check ----------------
   bit def_done = 0;

   initial begin
      int low, high, order_bad, busy_bad;
      low = 0; high = 0; order_bad = 0; busy_bad = 0;
      d_rst = 1'b1; d_valid = 1'b0; d_data = 8'h00;
      repeat (3) tick();
      d_rst = 1'b0;
      @(negedge clk);
      check("def_reset_line", d_serial, 1);
      check("def_reset_ready", d_ready, 1);
      check("def_reset_busy", d_busy, 0);
      check("def_reset_count", d_count, 0);
      tick();
      d_data  = 8'hFF;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      @(negedge clk);
      check("def_push_line", d_serial, 1);
      check("def_push_count", d_count, 1);
      for (int i = 0; i < 10 * DSET; i++) begin
         @(negedge clk);
         if (d_serial === 1'b0) begin
            if (high != 0) order_bad++;
            low++;
         end else begin
            high++;
         end
         if (d_busy !== 1'b1) busy_bad++;
      end
      check("def_start_low_cycles", low, DSET);
      check("def_high_cycles", high, 9 * DSET);
      check("def_low_after_high", order_bad, 0);
      check("def_busy_drop_in_frame", busy_bad, 0);
      @(negedge clk);
      check("def_busy_after_frame", d_busy, 0);
      check("def_line_after_frame", d_serial, 1);
      def_done = 1;
   end

   // ---------------- main stimulus ----------------
   initial begin
      int t;
      rst = 1'b1; data_in = 8'h00; data_in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single byte from idle
      send(8'hA5);
      wait_idle(300);

      // burst of ten bytes held valid: fills the FIFO and stalls
      for (int i = 0; i < 10; i++) send(8'(i));
      wait_idle(2000);

      // random bytes with random gaps and bursts (pointer wrap, push on pop edges)
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 120)) tick();
         send(8'($urandom));
      end
      wait_idle(6000);

      // reset during data bit 4 of 0x3C with two bytes queued
      send(8'h3C);
      send(8'h11);
      send(8'h22);
      repeat (50) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (300) tick();
      send(8'h55);
      wait_idle(300);

      // valid held through full periods with data changing every cycle
      for (int i = 0; i < 400; i++) begin
         data_in = 8'($urandom);
         data_in_valid = 1'b1;
         tick();
      end
      data_in_valid = 1'b0;
      wait_idle(20000);

      t = 0;
      while (!def_done && t < 10000) begin
         tick();
         t++;
      end
      if (!def_done) begin
         n_vec++;
         n_bad++;
         $display("FAIL default_rate_timeout: frame check unfinished, expected finished");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_transmitter_buffered.md
# uart_transmitter_buffered

Serial transmit end of the on-chip UART link: accepts bytes from the CPU-side IO controller over a ready/valid handshake and shifts them out on FPGA_SERIAL_TX as standard 8N1 frames. An internal FIFO decouples store bursts from the baud rate, so the core is stalled only when the FIFO is full. It pairs with the existing UART receive path and sits between io_control and the FPGA_SERIAL_TX pin.

## Interface
- CLOCK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- FIFO_DEPTH, 8: transmit buffer entries. Must be a power of two, ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  data_in is valid this cycle.
- data_in_ready  output  1  FIFO can accept a byte this cycle.
- serial_out  output  1  UART line; idle high.
- tx_busy  output  1  a frame is in progress, or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes currently buffered.

## Operation
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division). Each line bit is held for exactly SYMBOL_EDGE_TIME cycles.
- Frame format, 10 bits: start bit (0), then data[0]..data[7] (LSB first), then stop bit (1). No parity.
- Push: a byte is written on any rising edge where data_in_valid && data_in_ready.
  - data_in_ready = !full && !rst.
  - A push while full cannot occur. data_in_valid with ready low has no effect.
  - The producer may hold data_in_valid high for a burst.
- FIFO is circular:
  - read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH;
  - fifo_count is maintained separately;
  - full = (count == FIFO_DEPTH), empty = (count == 0).
- Simultaneous push and pop: count is unchanged and both pointers advance. A pop and a push to the same slot in the same cycle is legal; the popped value is the old entry.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial_out = 1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START.
  - START: serial_out = 0 for SYMBOL_EDGE_TIME cycles, then go to DATA.
  - DATA: serial_out = shift[0]. Shift right and increment the bit index every SYMBOL_EDGE_TIME cycles. After bit 7 completes, go to STOP.
  - STOP: serial_out = 1 for SYMBOL_EDGE_TIME cycles. In the last STOP cycle:
    - if the FIFO is non-empty, pop the next byte and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: width $clog2(SYMBOL_EDGE_TIME). It counts 0..SYMBOL_EDGE_TIME-1, and the bit ends when it reaches SYMBOL_EDGE_TIME-1.
- tx_busy = (state != IDLE) || !empty.
- serial_out is driven from a register (glitch-free).

## Timing
- Values while rst is high, and in the first cycle after it falls:
  - serial_out = 1, state = IDLE, fifo_count = 0, tx_busy = 0, pointers = 0;
  - data_in_ready = 0 while rst is high and 1 in the first cycle after.
- Latency: push into an empty FIFO while IDLE at edge N gives pop at edge N+1, and serial_out falls at edge N+1. Push-to-start-bit is 1 cycle.
- Frame length: exactly 10 × SYMBOL_EDGE_TIME cycles. Back-to-back frames are contiguous: the next start bit begins on the cycle after the last stop cycle.
- The pop occurs on the edge that enters START, so data_in_ready rises in the cycle after a full FIFO pops.
- Reset mid-frame: at the next edge serial_out = 1 and the FIFO is flushed. The partial frame is abandoned; buffered bytes are never sent.
- A byte pushed in the same cycle as rst is discarded.

## Test plan
- Single byte (CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10): push 0xA5 when idle.
  - serial_out samples at mid-bit read 0,1,0,1,0,0,1,0,1,1.
  - Each bit lasts 10 cycles; tx_busy stays high for 100 cycles; then the line is idle high.
- Burst to full (FIFO_DEPTH=8): hold valid with bytes 0x00..0x09.
  - data_in_ready drops after 9 accepts (8 buffered plus 1 popped into the shifter), with fifo_count = 8.
  - Ready reasserts after the first frame's STOP.
  - All 10 bytes arrive in order with zero inter-frame gap (1000 cycles total).
- Simultaneous push/pop: with 3 bytes buffered, push exactly on the STOP→START pop edge.
  - fifo_count stays 3.
  - Order is preserved, including across pointer wrap after 12+ bytes.
- Reset mid-frame: assert rst during DATA bit 4 of 0x3C with 2 bytes queued.
  - serial_out = 1 on the next edge and fifo_count = 0.
  - No further frames are sent; a post-reset push of 0x55 transmits correctly.
- Default parameters: 50 MHz / 115200 gives SYMBOL_EDGE_TIME = 434. Verify a 4340-cycle frame for 0xFF: start low for 434 cycles, then high for 3906 cycles.
- Valid without ready: hold data_in_valid high while the FIFO is full, changing data_in each cycle.
  - Only bytes accepted on handshake edges are transmitted.
